// File: rtl/dmac_top.sv
// Two-channel AHB bus-master DMA: fetches a 4-word descriptor per request, then
// copies data as read-burst / write-burst pairs through a 16-word buffer.
module dmac_top (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] MRData,
   input  logic        HReady,
   input  logic [1:0]  M_HResp,
   input  logic [1:0]  DmacReq,
   input  logic        Bus_Grant,
   output logic [31:0] MAddress,
   output logic [31:0] MWData,
   output logic [3:0]  MBurst_Size,
   output logic        MWrite,
   output logic [1:0]  MTrans,
   output logic [3:0]  MWStrb,
   output logic        Bus_Req,
   output logic        Interrupt,
   output logic [1:0]  ReqAck
);

   typedef enum logic [2:0] {
      S_IDLE, S_BUS_REQ, S_DESC, S_READ, S_WRITE, S_DONE
   } state_t;

   localparam logic [1:0]  TR_IDLE    = 2'b00;
   localparam logic [1:0]  TR_NONSEQ  = 2'b10;
   localparam logic [1:0]  TR_SEQ     = 2'b11;
   localparam logic [1:0]  RESP_ERROR = 2'b01;
   localparam logic [31:0] DESC_BASE0 = 32'h0000_00A0;
   localparam logic [31:0] DESC_BASE1 = 32'h0000_00B0;

   state_t      state_q, state_d;
   logic [1:0]  ack_q, ack_d;
   logic        irq_q, irq_d;
   logic        ch_q, ch_d;
   logic [31:0] src_q, src_d;
   logic [31:0] dst_q, dst_d;
   logic [31:0] rem_q, rem_d;
   logic [3:0]  blen_q, blen_d;
   logic [3:0]  bp_q, bp_d;
   logic        ien_q, ien_d;
   logic [3:0]  strb_q, strb_d;

   // Address-phase registers drive the bus directly; dphase tracks the data phase.
   logic [31:0] addr_q, addr_d;
   logic [1:0]  trans_q, trans_d;
   logic        write_q, write_d;
   logic        dphase_q, dphase_d;
   logic        dwrite_q, dwrite_d;
   logic [4:0]  acnt_q, acnt_d;
   logic [4:0]  dcnt_q, dcnt_d;
   logic [3:0]  wr_ptr_q, wr_ptr_d;
   logic [3:0]  rd_ptr_q, rd_ptr_d;
   logic [31:0] wdata_q;
   logic [31:0] buf_mem [16];

   logic        push, pop;
   logic        advance, addr_acc, data_done, bus_err;
   logic [31:0] rem_new, base;
   logic [4:0]  nb;
   logic        wr_n;

   function automatic logic [3:0] lane_strb(input logic [1:0] hsize, input logic [1:0] ofs);
      logic [3:0] s;
      case (hsize)
         2'b00:   s = 4'b0001 << ofs;
         2'b01:   s = (ofs == 2'b00) ? 4'b0011 : ((ofs == 2'b10) ? 4'b1100 : 4'b0000);
         2'b10:   s = 4'b1111;
         default: s = 4'b0000;
      endcase
      return s;
   endfunction

   function automatic logic [3:0] burst_len(input logic [31:0] rem, input logic [3:0] b);
      return (rem < {28'd0, b}) ? rem[3:0] : b;
   endfunction

   always_comb begin
      // With nothing in flight a low HReady has nothing to hold, so issue freely.
      advance   = HReady || (trans_q == TR_IDLE && !dphase_q);
      addr_acc  = HReady && (trans_q != TR_IDLE);
      data_done = HReady && dphase_q;
      bus_err   = data_done && (M_HResp == RESP_ERROR);
   end

   always_comb begin
      state_d  = state_q;
      ack_d    = ack_q;
      irq_d    = irq_q;
      ch_d     = ch_q;
      src_d    = src_q;
      dst_d    = dst_q;
      rem_d    = rem_q;
      blen_d   = blen_q;
      bp_d     = bp_q;
      ien_d    = ien_q;
      strb_d   = strb_q;
      addr_d   = addr_q;
      trans_d  = trans_q;
      write_d  = write_q;
      dphase_d = dphase_q;
      dwrite_d = dwrite_q;
      acnt_d   = acnt_q;
      dcnt_d   = dcnt_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      push     = 1'b0;
      pop      = 1'b0;
      rem_new  = rem_q - {28'd0, bp_q};
      base     = 32'd0;
      nb       = 5'd0;
      wr_n     = 1'b0;

      if (advance) begin
         dphase_d = addr_acc;
         dwrite_d = write_q;
         if (addr_acc) acnt_d = acnt_q + 5'd1;
         if (data_done) dcnt_d = dcnt_q + 5'd1;
         if (addr_acc && write_q) begin
            pop      = 1'b1;
            rd_ptr_d = rd_ptr_q + 4'd1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (DmacReq != 2'b00) begin
               state_d  = S_BUS_REQ;
               ch_d     = DmacReq[1];
               ack_d    = DmacReq[1] ? 2'b10 : 2'b01;
               irq_d    = 1'b0;
               ien_d    = 1'b0;
               wr_ptr_d = 4'd0;
               rd_ptr_d = 4'd0;
            end
         end
         S_BUS_REQ: begin
            if (Bus_Grant) begin
               state_d = S_DESC;
               acnt_d  = 5'd0;
               dcnt_d  = 5'd0;
            end
         end
         S_DESC: begin
            if (data_done) begin
               case (dcnt_q[1:0])
                  2'd0:    src_d = MRData;
                  2'd1:    dst_d = MRData;
                  2'd2:    rem_d = MRData;
                  default: begin
                     blen_d  = (MRData[3:0] == 4'd0) ? 4'd1 : MRData[3:0];
                     ien_d   = MRData[16];
                     strb_d  = lane_strb(MRData[5:4], src_q[1:0]);
                     bp_d    = burst_len(rem_q, blen_d);
                     state_d = (rem_q == 32'd0) ? S_DONE : S_READ;
                     acnt_d  = 5'd0;
                     dcnt_d  = 5'd0;
                  end
               endcase
            end
         end
         S_READ: begin
            if (data_done && !bus_err) begin
               push     = 1'b1;
               wr_ptr_d = wr_ptr_q + 4'd1;
               if (dcnt_d == {1'b0, bp_q}) begin
                  state_d = S_WRITE;
                  acnt_d  = 5'd0;
                  dcnt_d  = 5'd0;
               end
            end
         end
         S_WRITE: begin
            if (data_done && dcnt_d == {1'b0, bp_q}) begin
               src_d   = src_q + {26'd0, bp_q, 2'b00};
               dst_d   = dst_q + {26'd0, bp_q, 2'b00};
               rem_d   = rem_new;
               bp_d    = burst_len(rem_new, blen_q);
               state_d = (rem_new == 32'd0) ? S_DONE : S_READ;
               acnt_d  = 5'd0;
               dcnt_d  = 5'd0;
            end
         end
         S_DONE: begin
            // A data phase left over from an aborted burst must still finish.
            if (!dphase_q || HReady) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (bus_err && (state_q inside {S_DESC, S_READ, S_WRITE})) state_d = S_DONE;
      if (state_d == S_DONE && state_q != S_DONE) irq_d = ien_d || bus_err;

      // Next address phase is derived from where the FSM is heading.
      case (state_d)
         S_DESC:  begin base = ch_d ? DESC_BASE1 : DESC_BASE0; nb = 5'd4; wr_n = 1'b0; end
         S_READ:  begin base = {src_d[31:2], 2'b00}; nb = {1'b0, bp_d}; wr_n = 1'b0; end
         S_WRITE: begin base = dst_d; nb = {1'b0, bp_d}; wr_n = 1'b1; end
         default: begin base = 32'd0; nb = 5'd0; wr_n = 1'b0; end
      endcase

      if (advance) begin
         if (acnt_d < nb && Bus_Grant) begin
            trans_d = (acnt_d == 5'd0 || trans_q == TR_IDLE) ? TR_NONSEQ : TR_SEQ;
            addr_d  = base + {25'd0, acnt_d, 2'b00};
            write_d = wr_n;
         end else begin
            trans_d = TR_IDLE;
            write_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         ack_q    <= 2'b00;
         irq_q    <= 1'b0;
         ch_q     <= 1'b0;
         src_q    <= 32'd0;
         dst_q    <= 32'd0;
         rem_q    <= 32'd0;
         blen_q   <= 4'd0;
         bp_q     <= 4'd0;
         ien_q    <= 1'b0;
         strb_q   <= 4'd0;
         addr_q   <= 32'd0;
         trans_q  <= TR_IDLE;
         write_q  <= 1'b0;
         dphase_q <= 1'b0;
         dwrite_q <= 1'b0;
         acnt_q   <= 5'd0;
         dcnt_q   <= 5'd0;
         wr_ptr_q <= 4'd0;
         rd_ptr_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         ack_q    <= ack_d;
         irq_q    <= irq_d;
         ch_q     <= ch_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         rem_q    <= rem_d;
         blen_q   <= blen_d;
         bp_q     <= bp_d;
         ien_q    <= ien_d;
         strb_q   <= strb_d;
         addr_q   <= addr_d;
         trans_q  <= trans_d;
         write_q  <= write_d;
         dphase_q <= dphase_d;
         dwrite_q <= dwrite_d;
         acnt_q   <= acnt_d;
         dcnt_q   <= dcnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) buf_mem[wr_ptr_q] <= MRData;
   end

   // Registered buffer read: the popped word lands on MWData for the data phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      wdata_q <= 32'd0;
      else if (pop) wdata_q <= buf_mem[rd_ptr_q];
   end

   assign MAddress    = addr_q;
   assign MTrans      = trans_q;
   assign MWrite      = write_q;
   assign MWData      = wdata_q;
   assign MWStrb      = (dphase_q && dwrite_q) ? strb_q : 4'b0000;
   assign MBurst_Size = (state_q == S_READ || state_q == S_WRITE) ? bp_q : 4'd0;
   assign Bus_Req     = state_q inside {S_BUS_REQ, S_DESC, S_READ, S_WRITE};
   assign ReqAck      = Bus_Req ? ack_q : 2'b00;
   assign Interrupt   = irq_q;

endmodule

// File: tb/tb_dmac_top.sv
// Directed bench for dmac_top: AHB memory slave model plus transfer scenarios.
module tb_dmac_top;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] MRData = 32'd0;
   logic        HReady = 1'b1;
   logic [1:0]  M_HResp = 2'b00;
   logic [1:0]  DmacReq = 2'b00;
   logic        Bus_Grant = 1'b0;
   logic [31:0] MAddress, MWData;
   logic [3:0]  MBurst_Size, MWStrb;
   logic        MWrite, Bus_Req, Interrupt;
   logic [1:0]  MTrans, ReqAck;

   dmac_top dut (
      .clk(clk), .rst(rst), .MRData(MRData), .HReady(HReady), .M_HResp(M_HResp),
      .DmacReq(DmacReq), .Bus_Grant(Bus_Grant), .MAddress(MAddress), .MWData(MWData),
      .MBurst_Size(MBurst_Size), .MWrite(MWrite), .MTrans(MTrans), .MWStrb(MWStrb),
      .Bus_Req(Bus_Req), .Interrupt(Interrupt), .ReqAck(ReqAck)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [31:0] mem [2048];
   logic [31:0] src_copy [64];

   int  cyc = 0, rc = 0, gd = 1, err_beat = -1, rd_cnt = 0;
   int  wr_addr_n = 0, strb_bad = 0;
   bit  stall_en = 0, dp_v = 0, dp_w = 0, dp_d = 0, first_v = 0;
   logic [31:0] dp_a = 0, first_addr = 0, rd_sig = 0, wr_sig = 0;
   logic [3:0]  strb_exp = 4'd0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Slave, arbiter and stall generator, all updated mid-cycle.
   always @(negedge clk) begin
      cyc++;
      HReady  = !(stall_en && (cyc % 5 == 3));
      M_HResp = 2'b00;
      MRData  = 32'd0;
      if (Bus_Req) rc++; else rc = 0;
      Bus_Grant = Bus_Req && (rc > gd);
      if (rst) begin
         dp_v = 0;
      end else begin
         if (dp_v) begin
            if (dp_w) begin
               if (HReady) begin
                  for (int i = 0; i < 4; i++)
                     if (MWStrb[i]) mem[dp_a[12:2]][8*i +: 8] = MWData[8*i +: 8];
                  if (MWStrb != strb_exp) strb_bad++;
               end
            end else begin
               MRData = mem[dp_a[12:2]];
               if (dp_d) begin
                  if (rd_cnt == err_beat) M_HResp = 2'b01;
                  if (HReady) rd_cnt++;
               end
            end
         end
         if (HReady) begin
            dp_v = MTrans[1];
            dp_a = MAddress;
            dp_w = MWrite;
            dp_d = (MBurst_Size != 4'd0);
            if (MTrans[1]) begin
               if (!first_v) begin first_addr = MAddress; first_v = 1; end
               if (MTrans == 2'b10 && MBurst_Size != 4'd0) begin
                  if (MWrite) wr_sig = {wr_sig[27:0], MBurst_Size};
                  else        rd_sig = {rd_sig[27:0], MBurst_Size};
               end
               if (MWrite) wr_addr_n++;
            end
         end
      end
   end

   task automatic cyc_wait(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic clear_log();
      rd_sig = 0; wr_sig = 0; wr_addr_n = 0; strb_bad = 0; rd_cnt = 0; first_v = 0;
   endtask

   task automatic set_desc(input int base, input logic [31:0] w0, w1, w2, w3);
      mem[(base >> 2)]     = w0;
      mem[(base >> 2) + 1] = w1;
      mem[(base >> 2) + 2] = w2;
      mem[(base >> 2) + 3] = w3;
   endtask

   task automatic do_request(input logic [1:0] req, output logic [1:0] ack);
      DmacReq = req;
      ack = 2'b00;
      for (int i = 0; i < 20 && ack == 2'b00; i++) begin
         @(posedge clk); #1;
         ack = ReqAck;
      end
      DmacReq = 2'b00;
   endtask

   task automatic wait_done(output bit ok);
      ok = 0;
      for (int i = 0; i < 3000; i++) begin
         if (!Bus_Req) begin ok = 1; break; end
         @(posedge clk); #1;
      end
   endtask

   task automatic check_words(input string tag, input int src, input int dst, input int n);
      int bad = 0;
      for (int i = 0; i < n; i++)
         if (mem[(dst >> 2) + i] !== src_copy[(src >> 2) + i]) bad++;
      check_eq(tag, bad, 0);
   endtask

   task automatic run_xfer(input string tag, input logic [1:0] req, input logic [1:0] exp_ack,
                           input logic exp_irq, input logic [31:0] exp_rd, input logic [31:0] exp_wr);
      logic [1:0] ack;
      bit ok;
      clear_log();
      do_request(req, ack);
      check_eq({tag, "_ack"}, ack, exp_ack);
      wait_done(ok);
      check_eq({tag, "_done"}, ok, 1);
      check_eq({tag, "_ack_clr"}, ReqAck, 2'b00);
      check_eq({tag, "_irq"}, Interrupt, exp_irq);
      check_eq({tag, "_rd_bursts"}, rd_sig, exp_rd);
      check_eq({tag, "_wr_bursts"}, wr_sig, exp_wr);
      check_eq({tag, "_strb"}, strb_bad, 0);
      cyc_wait(3);
      check_eq({tag, "_idle"}, {Bus_Req, MTrans}, 3'b000);
      check_eq({tag, "_irq_hold"}, Interrupt, exp_irq);
      $display("xfer %s ack=%b irq=%b rd=%h wr=%h wbeats=%0d", tag, ack, Interrupt, rd_sig, wr_sig, wr_addr_n);
   endtask

   initial begin
      logic [1:0] ack;
      bit ok;
      int bad, waited;
      bit g;

      for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
      for (int i = 0; i < 64; i++) begin
         mem[i] = $urandom;
         src_copy[i] = mem[i];
      end

      #2;
      check_eq("rst_addr", MAddress, 0);
      check_eq("rst_ctl", {MWData, MBurst_Size, MWrite, MTrans, MWStrb, Bus_Req, Interrupt, ReqAck}, 0);
      cyc_wait(3);
      rst = 1'b0;
      cyc_wait(2);

      // Byte transfer from offset 3, burst 4, interrupt enabled
      set_desc(32'hA0, 32'h3, 32'h1000, 32'd18, 32'h0001_0004);
      strb_exp = 4'b1000;
      run_xfer("byte", 2'b01, 2'b01, 1'b1, 32'h44442, 32'h44442);
      check_eq("byte_wbeats", wr_addr_n, 18);
      bad = 0;
      for (int k = 0; k < 18; k++)
         if (mem[(32'h1000 >> 2) + k][31:24] !== src_copy[k][31:24]) bad++;
      check_eq("byte_lane3", bad, 0);
      bad = 0;
      for (int k = 0; k < 18; k++)
         if (mem[(32'h1000 >> 2) + k][23:0] !== 24'd0) bad++;
      check_eq("byte_other_lanes", bad, 0);

      // Word transfer, single 8-beat burst, HReady stalls
      set_desc(32'hA0, 32'h10, 32'h1040, 32'd8, 32'h0000_0028);
      strb_exp = 4'b1111;
      stall_en = 1;
      run_xfer("word", 2'b01, 2'b01, 1'b0, 32'h8, 32'h8);
      stall_en = 0;
      check_words("word_data", 32'h10, 32'h1040, 8);

      // Both requests: channel 1 wins and fetches from 0xB0
      set_desc(32'hB0, 32'h60, 32'h1100, 32'd2, 32'h0000_0022);
      run_xfer("prio", 2'b11, 2'b10, 1'b0, 32'h2, 32'h2);
      check_eq("prio_desc_addr", first_addr, 32'hB0);
      check_words("prio_data", 32'h60, 32'h1100, 2);

      // Grant withheld for 10 cycles
      set_desc(32'hA0, 32'h20, 32'h1180, 32'd4, 32'h0000_0024);
      gd = 10;
      clear_log();
      do_request(2'b01, ack);
      check_eq("gw_ack", ack, 2'b01);
      bad = (MTrans != 2'b00 || !Bus_Req) ? 1 : 0;
      waited = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         g = Bus_Grant;
         #1;
         if (g) break;
         waited++;
         if (MTrans != 2'b00 || !Bus_Req) bad++;
      end
      check_eq("gw_idle", bad, 0);
      check_eq("gw_wait_ge10", waited >= 10, 1);
      check_eq("gw_first_trans", MTrans, 2'b10);
      check_eq("gw_first_addr", MAddress, 32'hA0);
      wait_done(ok);
      check_eq("gw_done", ok, 1);
      cyc_wait(2);
      check_words("gw_data", 32'h20, 32'h1180, 4);
      $display("xfer grant_wait waited=%0d rd=%h wr=%h", waited, rd_sig, wr_sig);
      gd = 1;

      // ERROR on the second read beat aborts before any write
      set_desc(32'hA0, 32'h0, 32'h1200, 32'd8, 32'h0000_0024);
      err_beat = 1;
      run_xfer("err", 2'b01, 2'b01, 1'b1, 32'h4, 32'h0);
      err_beat = -1;
      check_eq("err_wbeats", wr_addr_n, 0);

      // Zero-length transfer: descriptor only, then DONE
      set_desc(32'hA0, 32'h0, 32'h1300, 32'd0, 32'h0001_0024);
      run_xfer("zero", 2'b01, 2'b01, 1'b1, 32'h0, 32'h0);
      check_eq("zero_wbeats", wr_addr_n, 0);
      check_eq("zero_desc_addr", first_addr, 32'hA0);

      // Reset asserted during a write burst
      set_desc(32'hA0, 32'h10, 32'h1280, 32'd8, 32'h0000_0024);
      clear_log();
      do_request(2'b01, ack);
      check_eq("rm_ack", ack, 2'b01);
      g = 0;
      for (int i = 0; i < 200; i++) begin
         if (MWrite && MTrans != 2'b00) begin g = 1; break; end
         @(posedge clk); #1;
      end
      check_eq("rm_in_write", g, 1);
      rst = 1'b1;
      #1;
      check_eq("rm_addr", MAddress, 0);
      check_eq("rm_ctl", {MWData, MBurst_Size, MWrite, MTrans, MWStrb, Bus_Req, Interrupt, ReqAck}, 0);
      cyc_wait(2);
      rst = 1'b0;
      cyc_wait(2);
      set_desc(32'hA0, 32'h30, 32'h12C0, 32'd4, 32'h0000_0024);
      run_xfer("post_rst", 2'b01, 2'b01, 1'b0, 32'h4, 32'h4);
      check_words("post_rst_data", 32'h30, 32'h12C0, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
